prng_xoshiro128pp_checker: RTL and testbench

- Receive-side checker for a xoshiro128++ word stream, e.g. from the generator across a link or FIFO.
- Holds a local xoshiro128++ state model, seeded out-of-band with the same seed as the source.
- Compares each accepted word against the expected next() result and tracks lock/failure status.
- Counts words and mismatches; sits at the sink end of PRNG-driven BIST and link-test datapaths.

---
 rtl/prng_xoshiro128pp_checker.sv | 174 +++++++++++++++++
 tb/tb_prng_xoshiro128pp_checker.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prng_xoshiro128pp_checker.sv
// prng_xoshiro128pp_checker
//
// Receive-side checker for a xoshiro128++ word stream. A local copy of the generator state is
// seeded out-of-band with the same seed as the source. Each accepted word is compared against
// the local next() result. The checker tracks lock and failure status, and counts accepted
// words and mismatches.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset (priority over everything)
//   i_cg                  clock-gate enable; low freezes all state and drops o_ready
//   i_seedValid           load i_seedS0..i_seedS3 this cycle; restarts checking
//   i_seedS0..i_seedS3    seed words
//   i_valid, i_data       received word handshake and data
//   o_ready               i_cg & !i_seedValid
//   o_expected            expected value of the next accepted word (combinational)
//   o_locked, o_failed    status (registered state)
//   o_mismatch            registered one-cycle pulse for a mismatching accepted word
//   o_wordCount           saturating count of accepted words since the last seed
//   o_errCount            saturating count of mismatches since the last seed
module prng_xoshiro128pp_checker #(
  parameter int unsigned WORDCOUNT_W     = 32,
  parameter int unsigned ERRCOUNT_W      = 16,
  parameter int unsigned LOCK_MATCHES    = 4,
  parameter int unsigned FAIL_MISMATCHES = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cg,
  input  logic                   i_seedValid,
  input  logic [31:0]            i_seedS0,
  input  logic [31:0]            i_seedS1,
  input  logic [31:0]            i_seedS2,
  input  logic [31:0]            i_seedS3,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [31:0]            i_data,
  output logic [31:0]            o_expected,
  output logic                   o_locked,
  output logic                   o_failed,
  output logic                   o_mismatch,
  output logic [WORDCOUNT_W-1:0] o_wordCount,
  output logic [ERRCOUNT_W-1:0]  o_errCount
);

  typedef enum logic [1:0] {StUnseeded, StChecking, StLocked, StFailed} state_e;

  localparam logic [8:0] LockTgt = 9'(LOCK_MATCHES);
  localparam logic [8:0] FailTgt = 9'(FAIL_MISMATCHES);

  state_e                 state_q, state_d;
  logic [31:0]            s0_q, s1_q, s2_q, s3_q;
  logic [31:0]            s0_d, s1_d, s2_d, s3_d;
  logic [WORDCOUNT_W-1:0] word_count_q, word_count_d;
  logic [ERRCOUNT_W-1:0]  err_count_q, err_count_d;
  logic [7:0]             match_run_q, match_run_d;
  logic [7:0]             mis_run_q, mis_run_d;
  logic                   mismatch_q, mismatch_d;

  logic [31:0] sum03;
  logic [31:0] t;
  logic [31:0] x0, x1, x2, x3;
  logic        accept;
  logic        mm;
  logic [8:0]  match_inc, mis_inc;

  assign o_ready     = i_cg & ~i_seedValid;
  assign accept      = i_valid & o_ready;
  assign sum03       = s0_q + s3_q;
  assign o_expected  = {sum03[24:0], sum03[31:25]} + s0_q;
  assign o_locked    = (state_q == StLocked);
  assign o_failed    = (state_q == StFailed);
  assign o_mismatch  = mismatch_q;
  assign o_wordCount = word_count_q;
  assign o_errCount  = err_count_q;

  // One xoshiro128 state step
  always_comb begin
    t  = s1_q << 9;
    x2 = s2_q ^ s0_q;
    x3 = s3_q ^ s1_q;
    x1 = s1_q ^ x2;
    x0 = s0_q ^ x3;
  end

  assign mm        = (i_data != o_expected);
  assign match_inc = {1'b0, match_run_q} + 9'd1;
  assign mis_inc   = {1'b0, mis_run_q} + 9'd1;

  always_comb begin
    state_d      = state_q;
    s0_d         = s0_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    s3_d         = s3_q;
    word_count_d = word_count_q;
    err_count_d  = err_count_q;
    match_run_d  = match_run_q;
    mis_run_d    = mis_run_q;
    mismatch_d   = 1'b0;

    if (i_seedValid) begin
      s0_d         = i_seedS0;
      s1_d         = i_seedS1;
      s2_d         = i_seedS2;
      s3_d         = i_seedS3;
      word_count_d = '0;
      err_count_d  = '0;
      match_run_d  = '0;
      mis_run_d    = '0;
      state_d      = StChecking;
    end else if (accept && (state_q != StUnseeded)) begin
      // The stream is assumed lossless, so the model steps on every accepted word
      s0_d       = x0;
      s1_d       = x1;
      s2_d       = x2 ^ t;
      s3_d       = {x3[20:0], x3[31:21]};
      mismatch_d = mm;
      if (~&word_count_q) word_count_d = word_count_q + WORDCOUNT_W'(1);
      if (mm && ~&err_count_q) err_count_d = err_count_q + ERRCOUNT_W'(1);

      case (state_q)
        StChecking: begin
          if (mm) begin
            match_run_d = '0;
          end else if (match_inc == LockTgt) begin
            match_run_d = '0;
            mis_run_d   = '0;
            state_d     = StLocked;
          end else begin
            match_run_d = match_inc[7:0];
          end
        end
        StLocked: begin
          if (!mm) begin
            mis_run_d = '0;
          end else if (mis_inc == FailTgt) begin
            mis_run_d = '0;
            state_d   = StFailed;
          end else begin
            mis_run_d = mis_inc[7:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StUnseeded;
      s0_q         <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      word_count_q <= '0;
      err_count_q  <= '0;
      match_run_q  <= '0;
      mis_run_q    <= '0;
      mismatch_q   <= 1'b0;
    end else if (i_cg) begin
      state_q      <= state_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      word_count_q <= word_count_d;
      err_count_q  <= err_count_d;
      match_run_q  <= match_run_d;
      mis_run_q    <= mis_run_d;
      mismatch_q   <= mismatch_d;
    end
  end

endmodule

// File: tb/tb_prng_xoshiro128pp_checker.sv
// Self-checking bench for prng_xoshiro128pp_checker. A behavioural model of the checker runs
// alongside two DUT instances (default widths, and a 2-bit error counter). The outputs are
// compared every cycle on the falling edge. Literal expectations pin the model to known values.
module tb_prng_xoshiro128pp_checker;

  localparam int LOCK = 4;
  localparam int FAIL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cg = 1'b1;
  logic        seed_valid = 1'b0;
  logic [31:0] seed [4];
  logic        valid = 1'b0;
  logic [31:0] data = '0;

  logic        ready, locked, failed, mismatch;
  logic [31:0] expected, word_count;
  logic [15:0] err_count;
  logic        ready_s, locked_s, failed_s, mismatch_s;
  logic [31:0] expected_s, word_count_s;
  logic [1:0]  err_count_s;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // Behavioural model: phase 0 unseeded, 1 checking, 2 locked, 3 failed
  logic [31:0] m_s [4];
  int          m_phase;
  int          m_run;
  longint      m_words, m_errs, m_errs_sat;
  bit          m_pulse;

  always #5 clk = ~clk;

  prng_xoshiro128pp_checker dut (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_seedValid(seed_valid),
    .i_seedS0(seed[0]), .i_seedS1(seed[1]), .i_seedS2(seed[2]), .i_seedS3(seed[3]),
    .i_valid(valid), .o_ready(ready), .i_data(data), .o_expected(expected),
    .o_locked(locked), .o_failed(failed), .o_mismatch(mismatch),
    .o_wordCount(word_count), .o_errCount(err_count)
  );

  prng_xoshiro128pp_checker #(.ERRCOUNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_seedValid(seed_valid),
    .i_seedS0(seed[0]), .i_seedS1(seed[1]), .i_seedS2(seed[2]), .i_seedS3(seed[3]),
    .i_valid(valid), .o_ready(ready_s), .i_data(data), .o_expected(expected_s),
    .o_locked(locked_s), .o_failed(failed_s), .o_mismatch(mismatch_s),
    .o_wordCount(word_count_s), .o_errCount(err_count_s)
  );

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] xo_out(input logic [31:0] a, input logic [31:0] d);
    return rotl32(a + d, 7) + a;
  endfunction

  function automatic logic [31:0] model_out();
    return xo_out(m_s[0], m_s[3]);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_advance();
    logic [31:0] a, b, c, d;
    a = m_s[0]; b = m_s[1]; c = m_s[2]; d = m_s[3];
    c = c ^ a;
    d = d ^ b;
    m_s[1] = b ^ c;
    m_s[0] = a ^ d;
    m_s[2] = c ^ (b << 9);
    m_s[3] = rotl32(d, 11);
  endtask

  task automatic model_step();
    bit bad;
    if (rst) begin
      m_phase = 0; m_run = 0; m_pulse = 0;
      m_words = 0; m_errs = 0; m_errs_sat = 0;
      for (int i = 0; i < 4; i++) m_s[i] = '0;
    end else if (cg) begin
      m_pulse = 0;
      if (seed_valid) begin
        for (int i = 0; i < 4; i++) m_s[i] = seed[i];
        m_phase = 1; m_run = 0;
        m_words = 0; m_errs = 0; m_errs_sat = 0;
      end else if (valid && m_phase != 0) begin
        bad = (data != model_out());
        m_pulse = bad;
        if (m_words < 64'hFFFF_FFFF) m_words++;
        if (bad && m_errs < 65535) m_errs++;
        if (bad && m_errs_sat < 3) m_errs_sat++;
        model_advance();
        if (m_phase == 1) begin
          if (bad) m_run = 0;
          else begin
            m_run++;
            if (m_run == LOCK) begin m_phase = 2; m_run = 0; end
          end
        end else if (m_phase == 2) begin
          if (bad) begin
            m_run++;
            if (m_run == FAIL) m_phase = 3;
          end else m_run = 0;
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (cmp_en) begin
      check("ready", ready, cg & ~seed_valid);
      check("ready_sat", ready_s, cg & ~seed_valid);
      if (m_phase != 0) check("expected", expected, model_out());
      check("locked", locked, m_phase == 2);
      check("failed", failed, m_phase == 3);
      check("mismatch", mismatch, m_pulse);
      check("word_count", word_count, m_words);
      check("err_count", err_count, m_errs);
      check("err_count_sat", err_count_s, m_errs_sat);
      check("locked_sat", locked_s, m_phase == 2);
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic sv, input logic c,
                       input logic r);
    valid = v; data = d; seed_valid = sv; cg = c; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic feed_good(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, model_out(), 1'b0, 1'b1, 1'b0);
  endtask

  task automatic feed_bad();
    drive(1'b1, model_out() ^ 32'h1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic random_seed();
    for (int i = 0; i < 4; i++) seed[i] = $urandom;
  endtask

  initial begin
    logic [31:0] pick;
    int          bad_pct;
    for (int i = 0; i < 4; i++) seed[i] = '0;
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    cmp_en = 1;
    drive(1'b1, 32'h1234, 1'b0, 1'b1, 1'b1);
    check("rst_word_count", word_count, 0);
    check("rst_locked", locked, 0);

    // Known seed {1,2,3,4}: first two outputs 0x281 and 0x180387
    seed[0] = 1; seed[1] = 2; seed[2] = 3; seed[3] = 4;
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("lit_exp0", expected, 32'h0000_0281);
    drive(1'b1, 32'h0000_0281, 1'b0, 1'b1, 1'b0);
    check("lit_exp1", expected, 32'h0018_0387);
    drive(1'b1, 32'h0018_0387, 1'b0, 1'b1, 1'b0);
    check("lit_wc2", word_count, 2);
    check("lit_ec0", err_count, 0);
    check("lit_mm0", mismatch, 0);
    feed_good(1);
    check("lit_not_locked3", locked, 0);
    feed_good(1);
    check("lit_locked4", locked, 1);

    // Three consecutive corrupted words -> failed
    for (int i = 0; i < 3; i++) begin
      feed_bad();
      check("lit_mm_pulse", mismatch, 1);
    end
    check("lit_ec3", err_count, 3);
    check("lit_failed", failed, 1);
    feed_good(2);
    check("lit_failed_sticky", failed, 1);
    check("lit_mm_clear", mismatch, 0);

    // Alternating mismatch/match while locked
    random_seed();
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    feed_good(4);
    feed_bad(); feed_good(1); feed_bad(); feed_good(1);
    check("lit_alt_ec2", err_count, 2);
    check("lit_alt_locked", locked, 1);
    check("lit_alt_failed", failed, 0);
    // Three more mismatches: 5 total, the 2-bit counter holds at 3
    feed_bad(); feed_bad(); feed_bad();
    check("lit_ec5", err_count, 5);
    check("lit_sat_ec3", err_count_s, 3);

    // Seed and word together: the word is dropped; state equals the seed
    random_seed();
    drive(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
    check("lit_seed_wc0", word_count, 0);
    check("lit_seed_state", expected, xo_out(seed[0], seed[3]));
    // Gated clock with a valid word: nothing moves
    valid = 1'b1; data = model_out(); seed_valid = 1'b0; cg = 1'b0;
    #1;
    check("lit_ready_cg0", ready, 0);
    drive(1'b1, model_out(), 1'b0, 1'b0, 1'b0);
    check("lit_cg_wc0", word_count, 0);
    check("lit_cg_state", expected, xo_out(seed[0], seed[3]));

    // Randomized traffic with segment-varying corruption rates
    bad_pct = 0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) begin
        pick = $urandom_range(3, 0);
        bad_pct = (pick == 0) ? 0 : (pick == 1) ? 3 : (pick == 2) ? 15 : 60;
      end
      if ($urandom_range(299, 0) == 0) random_seed();
      data = (m_phase != 0) ? model_out() : $urandom;
      if ($urandom_range(99, 0) < bad_pct) data = data ^ (32'h1 << $urandom_range(31, 0));
      drive($urandom_range(3, 0) != 0, data, $urandom_range(299, 0) == 0,
            $urandom_range(9, 0) != 0, $urandom_range(999, 0) == 0);
    end

    // Reset mid-stream
    random_seed();
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    feed_good(5);
    feed_bad();
    drive(1'b1, model_out(), 1'b0, 1'b1, 1'b1);
    check("lit_rst_locked", locked, 0);
    check("lit_rst_failed", failed, 0);
    check("lit_rst_mm", mismatch, 0);
    check("lit_rst_wc", word_count, 0);
    check("lit_rst_ec", err_count, 0);
    drive(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
    check("lit_unseeded_wc", word_count, 0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
